// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forward-mux selects and FSM states.
package hazard_pkg;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_W   = 2'b01;
  localparam logic [1:0] FWD_M   = 2'b10;

  typedef enum logic {
    StIdle    = 1'b0,
    StMemWait = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_select.sv
// One E-stage source operand's forward select: M ALU result beats W result beats regfile.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              RegWriteM,
  input  logic              MemReadM,
  input  logic [REG_AW-1:0] DestRegM,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] DestRegW,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_REG;
    // A load in M has no data yet, so it never sources a forward.
    if (RegWriteM && !MemReadM && (DestRegM != '0) && (DestRegM == src)) begin
      sel = FWD_M;
    end else if (RegWriteW && (DestRegW != '0) && (DestRegW == src)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit_mc.sv
// 5-stage hazard unit: E forwarding, load-use stall, branch flush, multi-cycle load wait.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned LOAD_LAT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteE,
  input  logic                      MemReadE,
  input  logic [REG_AW-1:0]         DestRegE,
  input  logic                      RegWriteM,
  input  logic                      MemReadM,
  input  logic [REG_AW-1:0]         DestRegM,
  input  logic                      RegWriteW,
  input  logic [REG_AW-1:0]         DestRegW,
  input  logic [NUM_SRC*REG_AW-1:0] SourceRegs_D,
  input  logic [NUM_SRC*REG_AW-1:0] SourceRegs_E,
  input  logic                      PCSrcE,
  output logic [NUM_SRC*2-1:0]      Forward_E,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic                      busy
);

  localparam int unsigned CntW = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'((LOAD_LAT > 0) ? LOAD_LAT - 1 : 0);

  logic [NUM_SRC*2-1:0] fwd;
  logic [NUM_SRC-1:0]   lu_vec;
  logic                 lu;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .REG_AW(REG_AW)
    ) u_fwd (
      .src      (SourceRegs_E[i*REG_AW +: REG_AW]),
      .RegWriteM(RegWriteM),
      .MemReadM (MemReadM),
      .DestRegM (DestRegM),
      .RegWriteW(RegWriteW),
      .DestRegW (DestRegW),
      .sel      (fwd[i*2 +: 2])
    );

    assign lu_vec[i] = (DestRegE == SourceRegs_D[i*REG_AW +: REG_AW]);
  end

  assign lu = MemReadE && RegWriteE && (DestRegE != '0) && (|lu_vec);

  state_t          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            served_q, served_d;
  logic            stall_fd, stall_em, flush_d, flush_e, flush_w;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    served_d = served_q;
    stall_fd = 1'b0;
    stall_em = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    flush_w  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // M advances on every idle cycle, so any earlier load's served mark expires here.
        served_d = 1'b0;
        if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (lu) begin
          stall_fd = 1'b1;
          flush_e  = 1'b1;
        end
        if (MemReadM && (LOAD_LAT > 0) && !served_q) begin
          state_d = StMemWait;
          cnt_d   = CntInit;
        end
      end
      StMemWait: begin
        stall_fd = 1'b1;
        stall_em = 1'b1;
        flush_w  = 1'b1;
        if (cnt_q == '0) begin
          state_d  = StIdle;
          served_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      served_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      served_q <= served_d;
    end
  end

  // Reset forces every control low immediately, not just the registered ones.
  assign Forward_E = rst ? '0 : fwd;
  assign StallF    = !rst && stall_fd;
  assign StallD    = !rst && stall_fd;
  assign StallE    = !rst && stall_em;
  assign StallM    = !rst && stall_em;
  assign FlushD    = !rst && flush_d;
  assign FlushE    = !rst && flush_e;
  assign FlushW    = !rst && flush_w;
  assign busy      = !rst && (state_q == StMemWait);

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc: three instances (LOAD_LAT 0, 2, 3) on shared inputs vs. a reference model.
module tb_hazard_unit_mc;

  localparam int unsigned AW = 5;
  localparam int unsigned NS = 2;
  localparam int unsigned ND = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          RegWriteE, MemReadE, RegWriteM, MemReadM, RegWriteW, PCSrcE;
  logic [AW-1:0] DestRegE, DestRegM, DestRegW;
  logic [NS*AW-1:0] SourceRegs_D, SourceRegs_E;

  // Per instance: {Forward_E[3:0], StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, busy}
  wire [11:0] act [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    hazard_unit_mc #(
      .REG_AW  (AW),
      .NUM_SRC (NS),
      .LOAD_LAT((g == 0) ? 0 : g + 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteE   (RegWriteE),
      .MemReadE    (MemReadE),
      .DestRegE    (DestRegE),
      .RegWriteM   (RegWriteM),
      .MemReadM    (MemReadM),
      .DestRegM    (DestRegM),
      .RegWriteW   (RegWriteW),
      .DestRegW    (DestRegW),
      .SourceRegs_D(SourceRegs_D),
      .SourceRegs_E(SourceRegs_E),
      .PCSrcE      (PCSrcE),
      .Forward_E   (act[g][11:8]),
      .StallF      (act[g][7]),
      .StallD      (act[g][6]),
      .StallE      (act[g][5]),
      .StallM      (act[g][4]),
      .FlushD      (act[g][3]),
      .FlushE      (act[g][2]),
      .FlushW      (act[g][1]),
      .busy        (act[g][0])
    );
  end

  int passed = 0;
  int total  = 0;

  // Model: remaining wait cycles of the load being served, and whether M's load was already served.
  int wait_left [ND];
  bit served    [ND];
  int stallm_cnt[ND];
  int busy_cnt  [ND];

  function automatic int lat_of(int k);
    return (k == 0) ? 0 : k + 1;
  endfunction

  task automatic check(string name, logic [11:0] got, logic [11:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  function automatic logic [11:0] model_out(int k);
    logic [3:0] fwd;
    bit lu;
    logic [7:0] ctl;
    if (rst) return 12'd0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] s;
      s = SourceRegs_E[i*AW +: AW];
      if (RegWriteM && !MemReadM && DestRegM != 0 && DestRegM == s) fwd[i*2 +: 2] = 2'b10;
      else if (RegWriteW && DestRegW != 0 && DestRegW == s)        fwd[i*2 +: 2] = 2'b01;
      else                                                          fwd[i*2 +: 2] = 2'b00;
    end
    lu = 0;
    for (int i = 0; i < NS; i++)
      if (MemReadE && RegWriteE && DestRegE != 0 && DestRegE == SourceRegs_D[i*AW +: AW]) lu = 1;
    if (wait_left[k] > 0) ctl = 8'b1111_0011;
    else if (PCSrcE)      ctl = 8'b0000_1100;
    else if (lu)          ctl = 8'b1100_0100;
    else                  ctl = 8'b0000_0000;
    return {fwd, ctl};
  endfunction

  task automatic model_tick();
    for (int k = 0; k < ND; k++) begin
      if (rst) begin
        wait_left[k] = 0;
        served[k]    = 0;
      end else if (wait_left[k] > 0) begin
        wait_left[k]--;
        if (wait_left[k] == 0) served[k] = 1;
      end else begin
        if (MemReadM && !served[k] && lat_of(k) > 0) wait_left[k] = lat_of(k);
        served[k] = 0;
      end
    end
  endtask

  // Check all instances mid-cycle, then advance the model over the next rising edge.
  task automatic step(string name);
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      check($sformatf("%s/lat%0d", name, lat_of(k)), act[k], model_out(k));
      if (act[k][4]) stallm_cnt[k]++;
      if (act[k][0]) busy_cnt[k]++;
    end
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic clear_inputs();
    {RegWriteE, MemReadE, RegWriteM, MemReadM, RegWriteW, PCSrcE} = '0;
    {DestRegE, DestRegM, DestRegW} = '0;
    SourceRegs_D = '0;
    SourceRegs_E = '0;
  endtask

  task automatic clear_counts();
    for (int k = 0; k < ND; k++) begin
      stallm_cnt[k] = 0;
      busy_cnt[k]   = 0;
    end
  endtask

  typedef struct packed {
    logic          rwe, mre;
    logic [AW-1:0] de;
    logic          rwm, mrm;
    logic [AW-1:0] dm;
    logic          rww;
    logic [AW-1:0] dw;
    logic [NS*AW-1:0] sd, se;
    logic          pc;
    logic [11:0]   exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rwe, logic mre, logic [4:0] de, logic rwm, logic mrm,
                              logic [4:0] dm, logic rww, logic [4:0] dw, logic [4:0] sd1,
                              logic [4:0] sd0, logic [4:0] se1, logic [4:0] se0, logic pc,
                              logic [11:0] exp);
    vec_t v;
    v = '{rwe: rwe, mre: mre, de: de, rwm: rwm, mrm: mrm, dm: dm, rww: rww, dw: dw,
          sd: {sd1, sd0}, se: {se1, se0}, pc: pc, exp: exp};
    vecs.push_back(v);
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    for (int k = 0; k < ND; k++) begin
      wait_left[k] = 0;
      served[k]    = 0;
    end
    clear_counts();
    @(posedge clk);
    #1;
    step("reset");
    rst = 1'b0;

    //   rwE mrE dE  rwM mrM dM  rwW dW  sD1 sD0 sE1 sE0 pc  expected
    add(0, 0, 0, 1, 0, 5, 1, 5, 0, 0, 0, 5, 0, 12'b0010_0000_0000);  // M beats W
    add(0, 0, 0, 0, 0, 5, 1, 5, 0, 0, 0, 5, 0, 12'b0001_0000_0000);  // W only
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b0000_0000_0000);  // x0 never forwards
    add(0, 0, 0, 1, 1, 9, 1, 4, 0, 0, 9, 3, 0, 12'b0000_0000_0000);  // load in M
    add(0, 0, 0, 1, 1, 9, 1, 9, 0, 0, 9, 3, 0, 12'b0100_0000_0000);  // load in M, W match
    add(1, 1, 7, 0, 0, 0, 0, 0, 7, 2, 0, 0, 0, 12'b0000_1100_0100);  // load-use src1
    add(1, 1, 7, 0, 0, 0, 0, 0, 3, 7, 0, 0, 1, 12'b0000_0000_1100);  // branch beats lu
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 12'b0000_0000_1100);  // branch only
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 12'b0000_0000_0000);  // lu on x0
    add(0, 1, 7, 0, 0, 0, 0, 0, 7, 7, 0, 0, 0, 12'b0000_0000_0000);  // no RegWriteE
    add(0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 3, 3, 0, 12'b1010_0000_0000);  // both from M
    add(0, 0, 0, 1, 0, 3, 1, 6, 0, 0, 6, 3, 0, 12'b0110_0000_0000);  // mixed M and W
    foreach (vecs[i]) begin
      {RegWriteE, MemReadE, DestRegE} = {vecs[i].rwe, vecs[i].mre, vecs[i].de};
      {RegWriteM, MemReadM, DestRegM} = {vecs[i].rwm, vecs[i].mrm, vecs[i].dm};
      {RegWriteW, DestRegW}           = {vecs[i].rww, vecs[i].dw};
      SourceRegs_D = vecs[i].sd;
      SourceRegs_E = vecs[i].se;
      PCSrcE       = vecs[i].pc;
      @(negedge clk);
      check($sformatf("vec%0d", i), act[0], vecs[i].exp);
      @(posedge clk);
      #1;
    end

    // Resync every instance and the model.
    clear_inputs();
    rst = 1'b1;
    step("resync");
    rst = 1'b0;

    // Load-use bubble lasts one cycle; branch overrides it.
    {RegWriteE, MemReadE, DestRegE} = {1'b1, 1'b1, 5'd7};
    SourceRegs_D = {5'd7, 5'd2};
    step("lu_bubble");
    clear_inputs();
    step("lu_after");
    {RegWriteE, MemReadE, DestRegE} = {1'b1, 1'b1, 5'd7};
    SourceRegs_D = {5'd7, 5'd2};
    PCSrcE = 1'b1;
    step("lu_branch");
    clear_inputs();
    step("lu_branch_after");

    // One load held in M for 5 cycles: lat3 waits once, lat2 sees it as two loads.
    clear_counts();
    {RegWriteM, MemReadM, DestRegM} = {1'b1, 1'b1, 5'd8};
    SourceRegs_E = {5'd8, 5'd8};
    for (int c = 0; c < 5; c++) begin
      PCSrcE = (c == 2);
      step($sformatf("wait%0d", c));
    end
    clear_inputs();
    for (int c = 0; c < 4; c++) step($sformatf("drain%0d", c));
    check("lat3_wait_cycles", 12'(stallm_cnt[2]), 12'd3);
    check("lat3_busy_cycles", 12'(busy_cnt[2]), 12'd3);
    check("lat2_wait_cycles", 12'(stallm_cnt[1]), 12'd4);
    check("lat0_wait_cycles", 12'(stallm_cnt[0]), 12'd0);

    // Reset during the second wait cycle drops everything at once.
    {RegWriteM, MemReadM, DestRegM} = {1'b1, 1'b1, 5'd4};
    step("rw_enter");
    step("rw_wait1");
    {RegWriteE, MemReadE, DestRegE} = {1'b1, 1'b1, 5'd3};
    SourceRegs_D = {5'd3, 5'd3};
    {RegWriteW, DestRegW} = {1'b1, 5'd1};
    SourceRegs_E = {5'd1, 5'd1};
    rst = 1'b1;
    step("rw_reset");
    rst = 1'b0;
    clear_inputs();
    for (int c = 0; c < 3; c++) step($sformatf("rw_post%0d", c));

    // Random traffic on small register numbers so matches are frequent.
    for (int n = 0; n < 300; n++) begin
      RegWriteE    = 1'($urandom_range(0, 1));
      MemReadE     = 1'($urandom_range(0, 1));
      DestRegE     = 5'($urandom_range(0, 3));
      RegWriteM    = 1'($urandom_range(0, 1));
      MemReadM     = ($urandom_range(0, 3) == 0);
      DestRegM     = 5'($urandom_range(0, 3));
      RegWriteW    = 1'($urandom_range(0, 1));
      DestRegW     = 5'($urandom_range(0, 3));
      SourceRegs_D = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      SourceRegs_E = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      PCSrcE       = ($urandom_range(0, 4) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      step($sformatf("rand%0d", n));
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
